// File: rtl/seq001_pkg.sv
`default_nettype none
// ============================================================================
// seq001_pkg : state encoding and line constants for the "001" sync link,
//              shared by the transmitter and the detector side.
// Rev 1.0
// ============================================================================
package seq001_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        DATA   = 3'd2,
        STUFF  = 3'd3,
        PARITY = 3'd4,
        END    = 3'd5
    } state_t;

    // Sent MSB first: 0,0,1
    localparam logic [2:0] SYNC_PAT   = 3'b001;
    localparam logic       IDLE_LEVEL = 1'b1;

endpackage : seq001_pkg
`default_nettype wire

// File: rtl/seq_001_tx.sv
`default_nettype none
// ============================================================================
// seq_001_tx : serial frame transmitter (idle 1s, sync 0,0,1, bit-stuffed
//              MSB-first payload). Define SEQ001_TX_PARITY_EN for a parity bit.
// Rev 1.0
// ============================================================================
module seq_001_tx
    import seq001_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IDLE_BITS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              busy,
    output logic              frame_done
);

    localparam int               REM_W    = $clog2(DATA_W + 1);
    localparam int               GAP_W    = $clog2(IDLE_BITS + 1);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(DATA_W);
    localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(IDLE_BITS);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [1:0]        sync_idx_q, sync_idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              accept;
    state_t            tail_state;
`ifdef SEQ001_TX_PARITY_EN
    logic              par_q, par_d;
    logic              par_sent_q, par_sent_d;
`endif

    assign in_ready   = (state_q == IDLE) && (gap_q >= GAP_FULL);
    assign accept     = in_valid && in_ready;
    assign tx_bit     = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

    // Where a frame goes once the payload (and its stuff bit) is exhausted
    always_comb begin
`ifdef SEQ001_TX_PARITY_EN
        tail_state = par_sent_q ? END : PARITY;
`else
        tail_state = END;
`endif
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rem_d      = rem_q;
        sync_idx_d = sync_idx_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
`ifdef SEQ001_TX_PARITY_EN
        par_d      = par_q;
        par_sent_d = par_sent_q;
`endif
        if (accept) begin
            state_d    = SYNC;
            shift_d    = in_data;
            sync_idx_d = 2'd0;
            tx_d       = IDLE_LEVEL;
`ifdef SEQ001_TX_PARITY_EN
            par_d      = ^in_data;
            par_sent_d = 1'b0;
`endif
        end else if (bit_en) begin
            case (state_q)
                IDLE: begin
                    tx_d = IDLE_LEVEL;
                    if (gap_q < GAP_FULL) gap_d = gap_q + 1'b1;
                end
                SYNC: begin
                    tx_d = SYNC_PAT[2'd2 - sync_idx_q];
                    if (sync_idx_q == 2'd2) begin
                        state_d = DATA;
                        rem_d   = REM_LOAD;
                    end else begin
                        sync_idx_d = sync_idx_q + 1'b1;
                    end
                end
                DATA: begin
                    tx_d    = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                    rem_d   = rem_q - 1'b1;
                    if (!shift_q[DATA_W-1])       state_d = STUFF;
                    else if (rem_q == REM_W'(1))  state_d = tail_state;
                end
                STUFF: begin
                    tx_d    = 1'b1;
                    state_d = (rem_q != '0) ? DATA : tail_state;
                end
`ifdef SEQ001_TX_PARITY_EN
                PARITY: begin
                    tx_d       = par_q;
                    par_sent_d = 1'b1;
                    state_d    = par_q ? END : STUFF;
                end
`endif
                END: begin
                    tx_d    = IDLE_LEVEL;
                    done_d  = 1'b1;
                    gap_d   = GAP_W'(1);
                    state_d = IDLE;
                end
                default: begin
                    tx_d    = IDLE_LEVEL;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            rem_q      <= '0;
            sync_idx_q <= 2'd0;
            gap_q      <= GAP_FULL;
            tx_q       <= IDLE_LEVEL;
            done_q     <= 1'b0;
`ifdef SEQ001_TX_PARITY_EN
            par_q      <= 1'b0;
            par_sent_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            rem_q      <= rem_d;
            sync_idx_q <= sync_idx_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef SEQ001_TX_PARITY_EN
            par_q      <= par_d;
            par_sent_q <= par_sent_d;
`endif
        end
    end

endmodule : seq_001_tx
`default_nettype wire

// File: tb/tb_seq_001_tx.sv
`default_nettype none
// ============================================================================
// tb_seq_001_tx : self-checking bench for seq_001_tx (directed table, corner
//                 sequences, randomized frames against a line-level model).
// Rev 1.0
// ============================================================================
module tb_seq_001_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       bit_en = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx_bit, busy, frame_done;

    int n_chk = 0;
    int n_err = 0;
    bit exp_q[$];

    typedef struct {
        logic [7:0]  data;
        int          nbits;
        logic [31:0] bits;
    } vec_t;
    vec_t tbl[3];

    seq_001_tx #(.DATA_W(8), .IDLE_BITS(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_en     (bit_en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_bit     (tx_bit),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line bits from the first sync bit up to the last frame bit before END
    task automatic model_frame(input logic [7:0] w);
        exp_q.delete();
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        for (int b = 7; b >= 0; b--) begin
            exp_q.push_back(w[b]);
            if (!w[b]) exp_q.push_back(1'b1);
        end
`ifdef SEQ001_TX_PARITY_EN
        exp_q.push_back(^w);
        if (!(^w)) exp_q.push_back(1'b1);
`endif
    endtask

    // One strobe every per clocks; tx_bit must hold on the non-strobe clocks
    task automatic bit_edge(input int per);
        logic held;
        held = tx_bit;
        for (int k = 0; k < per - 1; k++) begin
            bit_en = 1'b0;
            @(posedge clk); #1;
            chk("hold", 32'(tx_bit), 32'(held));
        end
        bit_en = 1'b1;
        @(posedge clk); #1;
        bit_en = (per == 1);
    endtask

    task automatic send_frame(input logic [7:0] w, input int per, input bit keep_valid);
        bit obs[$];
        int waits = 0;
        int n001 = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && waits < 50) begin
            bit_edge(per);
            waits++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        bit_en = (per == 1);
        @(posedge clk); #1;
        if (!keep_valid) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        chk("accept_tx", 32'(tx_bit), 32'd1);
        chk("accept_busy", 32'(busy), 32'd1);
        obs.push_back(1'b1); obs.push_back(1'b1);
        foreach (exp_q[i]) begin
            bit_edge(per);
            chk("tx_bit", 32'(tx_bit), 32'(exp_q[i]));
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("no_early_done", 32'(frame_done), 32'd0);
            obs.push_back(tx_bit);
        end
        bit_edge(per);
        chk("end_tx", 32'(tx_bit), 32'd1);
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("gap_ready_low", 32'(in_ready), 32'd0);
        obs.push_back(tx_bit);
        bit_edge(per);
        chk("done_pulse_end", 32'(frame_done), 32'd0);
        chk("gap_ready_high", 32'(in_ready), 32'd1);
        chk("idle_tx", 32'(tx_bit), 32'd1);
        obs.push_back(tx_bit);
        for (int i = 0; i + 2 < obs.size(); i++)
            if (!obs[i] && !obs[i+1] && obs[i+2]) n001++;
        chk("one_sync_per_frame", 32'(n001), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SEQ001_TX_PARITY_EN
        tbl[0] = '{8'hFF, 13, 32'b0011111111101};
        tbl[1] = '{8'h01, 19, 32'b0010101010101010111};
        tbl[2] = '{8'h03, 19, 32'b0010101010101011101};
`else
        tbl[0] = '{8'hFF, 11, 32'b00111111111};
        tbl[1] = '{8'h00, 19, 32'b0010101010101010101};
        tbl[2] = '{8'hA5, 15, 32'b001101101011011};
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_bit), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            exp_q.delete();
            for (int b = tbl[i].nbits - 1; b >= 0; b--) exp_q.push_back(tbl[i].bits[b]);
            send_frame(tbl[i].data, 1, 1'b0);
        end

        // 1-in-4 strobes: same bits, each held for four clocks
        exp_q.delete();
        for (int b = tbl[2].nbits - 1; b >= 0; b--) exp_q.push_back(tbl[2].bits[b]);
        send_frame(tbl[2].data, 4, 1'b0);

        // Back-to-back with in_valid held high through both frames
        model_frame(8'h3C);
        send_frame(8'h3C, 1, 1'b1);
        model_frame(8'hC3);
        send_frame(8'hC3, 1, 1'b0);

        // Reset in the middle of the payload
        in_data = 8'h5A; in_valid = 1'b1; bit_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_bit), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("postrst_ready", 32'(in_ready), 32'd1);
            chk("postrst_tx", 32'(tx_bit), 32'd1);
            chk("postrst_done", 32'(frame_done), 32'd0);
        end

        // Randomized frames, strobe spacing and idle gaps
        for (int n = 0; n < 30; n++) begin
            logic [7:0] w;
            int per;
            w   = 8'($urandom);
            per = $urandom_range(1, 3);
            repeat ($urandom_range(0, 3)) bit_edge(per);
            model_frame(w);
            send_frame(w, per, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_seq_001_tx
`default_nettype wire
